// File: rtl/ec_multiexp_seq.sv
// ec_multiexp_seq: sequencer for a windowed multi-scalar multiplication.
// For each window (most significant first) it doubles the accumulator
// WINDOW_BITS times, then reads every scalar and issues one table ADD per
// non-zero digit. One EC command is outstanding at a time.
// Optional feature macro: MULTIEXP_SKIP_DBL_EN -- omit DBL commands while the
// accumulator is still the point at infinity (no ADD accepted since CLR).
module ec_multiexp_seq #(
  parameter int unsigned DAT_BITS    = 256,
  parameter int unsigned WINDOW_BITS = 4,
  parameter int unsigned NUM_PTS     = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_sc_rd,
  output logic [9:0]          o_sc_addr,
  input  logic [DAT_BITS-1:0] i_sc_dat,
  output logic                o_cmd_val,
  input  logic                i_cmd_rdy,
  output logic [1:0]          o_cmd_op,
  output logic [15:0]         o_cmd_idx,
  input  logic                i_ec_done
);

  localparam int unsigned NUM_WIN = DAT_BITS / WINDOW_BITS;
  localparam int unsigned WIN_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam int unsigned DBL_W   = (WINDOW_BITS > 1) ? $clog2(WINDOW_BITS) : 1;
  localparam int unsigned DIG_MAX = (1 << WINDOW_BITS) - 1;

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(NUM_WIN - 1);
  localparam logic [DBL_W-1:0] DBL_LAST = DBL_W'(WINDOW_BITS - 1);
  localparam logic [9:0]       PT_LAST  = 10'(NUM_PTS - 1);

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_DBL = 2'd1;
  localparam logic [1:0] OP_ADD = 2'd2;
  localparam logic [1:0] OP_CLR = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR_ISSUE,
    S_CLR_WAIT,
    S_DBL_ISSUE,
    S_DBL_WAIT,
    S_SC_RD,
    S_SC_CHK,
    S_ADD_ISSUE,
    S_ADD_WAIT,
    S_FIN
  } state_t;

  state_t                 r_state;
  logic [WIN_W-1:0]       r_win;
  logic [DBL_W-1:0]       r_dbl;

  logic [WINDOW_BITS-1:0] w_digit;
  logic [15:0]            w_add_idx;
  logic                   w_skip_dbl;
  state_t                 w_adv_state;
  logic [WIN_W-1:0]       w_win_nxt;
  logic [9:0]             w_addr_nxt;
  logic                   w_adv_rd;
  logic                   w_adv_dbl;
  logic                   w_adv_fin;

  // Digit of the current window taken from the scalar returned by the read
  assign w_digit   = WINDOW_BITS'(i_sc_dat >> (32'(r_win) * WINDOW_BITS));
  // Table layout: DIG_MAX entries per point, entry d-1 holds d*P_i
  assign w_add_idx = 16'(o_sc_addr) * 16'(DIG_MAX) + 16'(w_digit) - 16'd1;

`ifdef MULTIEXP_SKIP_DBL_EN
  logic r_added;

  // Accumulator leaves infinity at the first accepted ADD of the run
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_added <= 1'b0;
    end else if (r_state == S_IDLE && i_start) begin
      r_added <= 1'b0;
    end else if (r_state == S_ADD_ISSUE && i_cmd_rdy) begin
      r_added <= 1'b1;
    end
  end

  assign w_skip_dbl = ~r_added;
`else
  assign w_skip_dbl = 1'b0;
`endif

  // Destination once the current scalar is finished: next scalar, next window or finish
  always_comb begin
    w_adv_state = S_FIN;
    w_win_nxt   = r_win;
    w_addr_nxt  = '0;
    if (o_sc_addr != PT_LAST) begin
      w_adv_state = S_SC_RD;
      w_addr_nxt  = o_sc_addr + 10'd1;
    end else if (r_win != '0) begin
      w_win_nxt   = r_win - WIN_W'(1);
      w_adv_state = w_skip_dbl ? S_SC_RD : S_DBL_ISSUE;
    end
  end

  assign w_adv_rd  = (w_adv_state == S_SC_RD);
  assign w_adv_dbl = (w_adv_state == S_DBL_ISSUE);
  assign w_adv_fin = (w_adv_state == S_FIN);

  // Sequencer FSM with registered command, read and status outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_win     <= '0;
      r_dbl     <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_sc_rd   <= 1'b0;
      o_sc_addr <= '0;
      o_cmd_val <= 1'b0;
      o_cmd_op  <= OP_NOP;
      o_cmd_idx <= '0;
    end else begin
      o_done  <= 1'b0;
      o_sc_rd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state   <= S_CLR_ISSUE;
            r_win     <= WIN_LAST;
            r_dbl     <= '0;
            o_sc_addr <= '0;
            o_busy    <= 1'b1;
            o_cmd_val <= 1'b1;
            o_cmd_op  <= OP_CLR;
            o_cmd_idx <= '0;
          end
        end
        S_CLR_ISSUE: begin
          if (i_cmd_rdy) begin
            r_state   <= S_CLR_WAIT;
            o_cmd_val <= 1'b0;
            o_cmd_op  <= OP_NOP;
          end
        end
        S_CLR_WAIT: begin
          if (i_ec_done) begin
            if (w_skip_dbl) begin
              r_state <= S_SC_RD;
              o_sc_rd <= 1'b1;
            end else begin
              r_state   <= S_DBL_ISSUE;
              o_cmd_val <= 1'b1;
              o_cmd_op  <= OP_DBL;
            end
          end
        end
        S_DBL_ISSUE: begin
          if (i_cmd_rdy) begin
            r_state   <= S_DBL_WAIT;
            o_cmd_val <= 1'b0;
            o_cmd_op  <= OP_NOP;
          end
        end
        S_DBL_WAIT: begin
          if (i_ec_done) begin
            if (r_dbl == DBL_LAST) begin
              r_dbl     <= '0;
              r_state   <= S_SC_RD;
              o_sc_rd   <= 1'b1;
              o_sc_addr <= '0;
            end else begin
              r_dbl     <= r_dbl + DBL_W'(1);
              r_state   <= S_DBL_ISSUE;
              o_cmd_val <= 1'b1;
              o_cmd_op  <= OP_DBL;
            end
          end
        end
        S_SC_RD: begin
          r_state <= S_SC_CHK;
        end
        S_SC_CHK: begin
          if (w_digit != '0) begin
            r_state   <= S_ADD_ISSUE;
            o_cmd_val <= 1'b1;
            o_cmd_op  <= OP_ADD;
            o_cmd_idx <= w_add_idx;
          end else begin
            r_state   <= w_adv_state;
            r_win     <= w_win_nxt;
            o_sc_addr <= w_addr_nxt;
            o_sc_rd   <= w_adv_rd;
            o_cmd_val <= w_adv_dbl;
            o_cmd_op  <= w_adv_dbl ? OP_DBL : OP_NOP;
            o_done    <= w_adv_fin;
          end
        end
        S_ADD_ISSUE: begin
          if (i_cmd_rdy) begin
            r_state   <= S_ADD_WAIT;
            o_cmd_val <= 1'b0;
            o_cmd_op  <= OP_NOP;
            o_cmd_idx <= '0;
          end
        end
        S_ADD_WAIT: begin
          if (i_ec_done) begin
            r_state   <= w_adv_state;
            r_win     <= w_win_nxt;
            o_sc_addr <= w_addr_nxt;
            o_sc_rd   <= w_adv_rd;
            o_cmd_val <= w_adv_dbl;
            o_cmd_op  <= w_adv_dbl ? OP_DBL : OP_NOP;
            o_done    <= w_adv_fin;
          end
        end
        S_FIN: begin
          r_state   <= S_IDLE;
          o_busy    <= 1'b0;
          o_sc_addr <= '0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
